// File: rtl/tdoa_pkg.sv
// tdoa_pkg: shared types, constants and small helpers for the TDOA direction estimator.
//   state_t      : FILL / COMPUTE / REPORT controller states
//   DATA_W       : raw I2S sample width
//   SAMPLE_W     : stored sample width (top bits of each raw sample)
//   ANGLE_CENTER : angle reported for zero lag
//   ANGLE_MAX    : upper bound of the reported angle
package tdoa_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam int DATA_W       = 18;
  localparam int SAMPLE_W     = 12;
  localparam int LAG_W        = 5;
  localparam int ANGLE_CENTER = 90;
  localparam int ANGLE_MAX    = 180;

  function automatic logic [LAG_W-1:0] lag_mag(input logic signed [LAG_W-1:0] l);
    return l[LAG_W-1] ? LAG_W'(-l) : LAG_W'(l);
  endfunction

  function automatic logic [7:0] clamp_angle(input int a);
    if (a < 0) return 8'd0;
    if (a > ANGLE_MAX) return 8'(ANGLE_MAX);
    return 8'(a);
  endfunction

endpackage

// File: rtl/tdoa_estimator_pair_sync.sv
// sample_pair_sync: pairs the two channel sample streams.
// Each channel owns a one-deep holding register and a pending flag; a pair is
// emitted (registered) once both channels have a sample, with same-cycle
// arrivals bypassing the holding registers.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   enable                  : high while frames are being filled; when low,
//                             incoming samples are discarded and pend flags clear
//   data0/1, data_rdy0/1    : raw 18-bit samples and their valid pulses
//   pair_valid, pair0/1     : one-cycle pulse with the truncated sample pair
//   overrun                 : sticky, a pending sample was overwritten
module sample_pair_sync
  import tdoa_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DATA_W-1:0]          data0,
  input  logic                       data_rdy0,
  input  logic [DATA_W-1:0]          data1,
  input  logic                       data_rdy1,
  output logic                       pair_valid,
  output logic signed [SAMPLE_W-1:0] pair0,
  output logic signed [SAMPLE_W-1:0] pair1,
  output logic                       overrun
);

  logic signed [SAMPLE_W-1:0] s0, s1, hold0, hold1;
  logic pend0, pend1, have0, have1;
  logic unused_lsbs;

  assign s0 = data0[DATA_W-1 -: SAMPLE_W];
  assign s1 = data1[DATA_W-1 -: SAMPLE_W];
  assign unused_lsbs = ^{data0[DATA_W-SAMPLE_W-1:0], data1[DATA_W-SAMPLE_W-1:0]};

  assign have0 = pend0 | data_rdy0;
  assign have1 = pend1 | data_rdy1;

  always_ff @(posedge clock) begin
    if (reset) begin
      pair_valid <= 1'b0;
      pair0      <= '0;
      pair1      <= '0;
      hold0      <= '0;
      hold1      <= '0;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      if (!enable) begin
        pend0 <= 1'b0;
        pend1 <= 1'b0;
      end else begin
        if ((data_rdy0 && pend0) || (data_rdy1 && pend1)) overrun <= 1'b1;
        if (have0 && have1) begin
          // newest sample wins on a same-cycle overwrite
          pair_valid <= 1'b1;
          pair0      <= data_rdy0 ? s0 : hold0;
          pair1      <= data_rdy1 ? s1 : hold1;
          pend0      <= 1'b0;
          pend1      <= 1'b0;
        end else begin
          if (data_rdy0) begin
            hold0 <= s0;
            pend0 <= 1'b1;
          end
          if (data_rdy1) begin
            hold1 <= s1;
            pend1 <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tdoa_estimator.sv
// tdoa_estimator: fills a frame of paired microphone samples, sweeps a
// cross-correlation over lags -MAX_LAG..+MAX_LAG (one MAC per cycle) and
// reports the best lag and the corresponding 0..180 degree angle.
// Optional build macro TDOA_ENERGY_GATE_EN: suppresses reports for frames whose
// channel-0 energy sum |x0| is below ENERGY_THRESH.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   data0/1, data_rdy0/1    : 18-bit two's complement samples and valid pulses
//   angle, lag              : last estimate (held between reports)
//   angle_valid             : one-cycle pulse when angle/lag update
//   busy                    : correlation in progress, input samples dropped
//   overrun                 : sticky, a pending sample was overwritten
//
// state   | meaning
// FILL    | storing sample pairs until the frame is full
// COMPUTE | correlation sweep, exactly COMPUTE_CYCLES long
// REPORT  | one cycle, publish the best lag and angle
module tdoa_estimator
  import tdoa_pkg::*;
#(
  parameter int          WINDOW        = 256,
  parameter int          MAX_LAG       = 8,
  parameter int          ANGLE_STEP    = 11,
  parameter logic [31:0] ENERGY_THRESH = 32'd4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data0,
  input  logic              data_rdy0,
  input  logic [DATA_W-1:0] data1,
  input  logic              data_rdy1,
  output logic [7:0]        angle,
  output logic [LAG_W-1:0]  lag,
  output logic              angle_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int AW             = $clog2(WINDOW);
  localparam int ACC_W          = 2*SAMPLE_W + AW;
  localparam int COMPUTE_CYCLES = (2*MAX_LAG + 1) * (WINDOW - 2*MAX_LAG) + 3;
  localparam int CNT_W          = $clog2(COMPUTE_CYCLES);
  localparam logic [AW-1:0] N_FIRST = AW'(MAX_LAG);
  localparam logic [AW-1:0] N_LAST  = AW'(WINDOW - 1 - MAX_LAG);
  localparam logic signed [LAG_W-1:0] LAG_FIRST = LAG_W'(-MAX_LAG);
  localparam logic signed [LAG_W-1:0] LAG_LAST  = LAG_W'(MAX_LAG);
  localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state;
  logic [AW-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  logic pair_valid;
  logic signed [SAMPLE_W-1:0] pair0, pair1;

  logic signed [SAMPLE_W-1:0] buf0 [WINDOW];
  logic signed [SAMPLE_W-1:0] buf1 [WINDOW];

  // address issue stage
  logic iss_on;
  logic [AW-1:0] n_iss, addr1;
  logic signed [LAG_W-1:0] lag_iss;

  // tags travel alongside the read and multiply stages
  logic signed [SAMPLE_W-1:0] rd0, rd1;
  logic v1, first1, last1, v2, first2, last2, c3;
  logic signed [LAG_W-1:0] lag1, lag2, lag3;
  logic signed [2*SAMPLE_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, best;
  logic signed [LAG_W-1:0] best_lag;
  logic better;

  assign addr1  = n_iss + AW'(lag_iss);
  assign better = (acc > best) || ((acc == best) && (lag_mag(lag3) < lag_mag(best_lag)));

  sample_pair_sync u_sync (
    .clock      (clock),
    .reset      (reset),
    .enable     (state == FILL),
    .data0      (data0),
    .data_rdy0  (data_rdy0),
    .data1      (data1),
    .data_rdy1  (data_rdy1),
    .pair_valid (pair_valid),
    .pair0      (pair0),
    .pair1      (pair1),
    .overrun    (overrun)
  );

`ifdef TDOA_ENERGY_GATE_EN
  logic [31:0] energy, energy_next;
  logic [SAMPLE_W-1:0] mag0;
  logic [32:0] energy_sum;
  assign mag0        = pair0[SAMPLE_W-1] ? SAMPLE_W'(-pair0) : SAMPLE_W'(pair0);
  assign energy_sum  = {1'b0, energy} + 33'(mag0);
  assign energy_next = energy_sum[32] ? '1 : energy_sum[31:0];
`else
  logic unused_cfg;
  assign unused_cfg = ^ENERGY_THRESH;
`endif

  // frame buffers: no reset so they map onto block RAM
  always_ff @(posedge clock) begin
    if (state == FILL && pair_valid) begin
      buf0[wr_ptr] <= pair0;
      buf1[wr_ptr] <= pair1;
    end
    rd0 <= buf0[n_iss];
    rd1 <= buf1[addr1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FILL;
      wr_ptr      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      angle_valid <= 1'b0;
      angle       <= 8'(ANGLE_CENTER);
      lag         <= '0;
      iss_on      <= 1'b0;
      n_iss       <= '0;
      lag_iss     <= '0;
      v1          <= 1'b0;
      first1      <= 1'b0;
      last1       <= 1'b0;
      lag1        <= '0;
      v2          <= 1'b0;
      first2      <= 1'b0;
      last2       <= 1'b0;
      lag2        <= '0;
      prod        <= '0;
      c3          <= 1'b0;
      lag3        <= '0;
      acc         <= '0;
      best        <= '0;
      best_lag    <= '0;
`ifdef TDOA_ENERGY_GATE_EN
      energy      <= '0;
`endif
    end else begin
      angle_valid <= 1'b0;

      v1     <= iss_on;
      first1 <= (n_iss == N_FIRST);
      last1  <= (n_iss == N_LAST);
      lag1   <= lag_iss;
      v2     <= v1;
      first2 <= first1;
      last2  <= last1;
      lag2   <= lag1;
      prod   <= (2*SAMPLE_W)'(rd0) * (2*SAMPLE_W)'(rd1);
      if (v2) acc <= first2 ? ACC_W'(prod) : acc + ACC_W'(prod);
      // acc holds the complete C(lag3) for exactly this one cycle
      c3     <= v2 & last2;
      lag3   <= lag2;
      if (c3 && better) begin
        best     <= acc;
        best_lag <= lag3;
      end

      if (iss_on) begin
        if (n_iss == N_LAST) begin
          n_iss <= N_FIRST;
          if (lag_iss == LAG_LAST) iss_on <= 1'b0;
          else lag_iss <= lag_iss + 5'sd1;
        end else begin
          n_iss <= n_iss + 1'b1;
        end
      end

      case (state)
        FILL: begin
          if (pair_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
`ifdef TDOA_ENERGY_GATE_EN
            energy <= energy_next;
`endif
            if (wr_ptr == AW'(WINDOW - 1)) begin
              state    <= COMPUTE;
              busy     <= 1'b1;
              cnt      <= CNT_W'(COMPUTE_CYCLES - 1);
              iss_on   <= 1'b1;
              n_iss    <= N_FIRST;
              lag_iss  <= LAG_FIRST;
              best     <= ACC_MIN;
              best_lag <= '0;
            end
          end
        end
        COMPUTE: begin
          if (cnt == '0) begin
            state <= REPORT;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REPORT: begin
`ifdef TDOA_ENERGY_GATE_EN
          if (energy >= ENERGY_THRESH) begin
            lag         <= best_lag;
            angle       <= clamp_angle(ANGLE_CENTER + int'(best_lag) * ANGLE_STEP);
            angle_valid <= 1'b1;
          end
          energy <= '0;
`else
          lag         <= best_lag;
          angle       <= clamp_angle(ANGLE_CENTER + int'(best_lag) * ANGLE_STEP);
          angle_valid <= 1'b1;
`endif
          state  <= FILL;
          wr_ptr <= '0;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_tdoa_estimator.sv
// Directed bench for tdoa_estimator; a second instance with ANGLE_STEP = 12
// shares the stimulus to exercise angle clamping.
module tb_tdoa_estimator;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [17:0] data0 = '0, data1 = '0;
  logic data_rdy0 = 1'b0, data_rdy1 = 1'b0;

  logic [7:0] angle, angle_b;
  logic [4:0] lag, lag_b;
  logic angle_valid, busy, overrun;
  logic angle_valid_b, busy_b, overrun_b;

  int total = 0;
  int bad   = 0;

  localparam logic [17:0] IMP = 18'd64000;
  localparam logic [17:0] BG  = 18'd131008;

  typedef struct {
    int l;
    int ang;
    int ang_b;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  tdoa_estimator dut (
    .clock(clock), .reset(reset),
    .data0(data0), .data_rdy0(data_rdy0), .data1(data1), .data_rdy1(data_rdy1),
    .angle(angle), .lag(lag), .angle_valid(angle_valid), .busy(busy), .overrun(overrun)
  );

  tdoa_estimator #(.ANGLE_STEP(12)) dut_b (
    .clock(clock), .reset(reset),
    .data0(data0), .data_rdy0(data_rdy0), .data1(data1), .data_rdy1(data_rdy1),
    .angle(angle_b), .lag(lag_b), .angle_valid(angle_valid_b), .busy(busy_b), .overrun(overrun_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int exp_angle(input int l, input int step);
    int a;
    a = 90 + l * step;
    if (a < 0) a = 0;
    if (a > 180) a = 180;
    return a;
  endfunction

  task automatic push_exp(input int l);
    exp_t e;
    e.l     = l;
    e.ang   = exp_angle(l, 11);
    e.ang_b = exp_angle(l, 12);
    sb.push_back(e);
  endtask

  // One frame of 256 pairs; p0/p1 place the impulses, unp replaces that pair
  // with an A,B-then-ch1 overrun sequence. x0[0..3] carry energy outside the
  // correlated range (n starts at MAX_LAG) unless bg is 0.
  task automatic run_frame(input int p0, input int p1, input int unp, input bit bg);
    for (int i = 0; i < 256; i++) begin
      if (i == unp) begin
        @(negedge clock); data0 = 18'(-64000); data_rdy0 = 1'b1;
        @(negedge clock); data0 = IMP;
        @(negedge clock); data_rdy0 = 1'b0; data1 = IMP; data_rdy1 = 1'b1;
        @(negedge clock); data_rdy1 = 1'b0;
      end else begin
        @(negedge clock);
        data0 = (i == p0) ? IMP : ((bg && i < 4) ? BG : 18'd0);
        data1 = (i == p1) ? IMP : 18'd0;
        data_rdy0 = 1'b1;
        data_rdy1 = 1'b1;
        @(negedge clock);
        data_rdy0 = 1'b0;
        data_rdy1 = 1'b0;
      end
    end
  endtask

  task automatic wait_report(input bit exp_valid);
    int k, rise, blen, vat;
    exp_t e;
    k = 0; rise = -1; blen = 0; vat = -1;
    while (k < 4400 && vat < 0) begin
      @(negedge clock);
      if (busy) begin
        if (rise < 0) rise = k;
        blen++;
      end
      if (angle_valid) vat = k;
      k++;
    end
    if (exp_valid) begin
      chk("valid_seen", 32'(vat >= 0), 32'd1);
      chk("busy_len", blen, 4083);
      chk("valid_latency", vat - rise, 4084);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("lag", 32'($signed(lag)), e.l);
        chk("angle", {24'd0, angle}, e.ang);
        chk("angle_step12", {24'd0, angle_b}, e.ang_b);
      end else begin
        chk("scoreboard_empty", sb.size(), 1);
      end
      @(negedge clock);
      chk("valid_pulse_width", {31'd0, angle_valid}, 32'd0);
    end else begin
      chk("no_valid", 32'(vat), -1);
    end
  endtask

  initial begin
    int k;
    bit seen;

    repeat (2) @(negedge clock);
    chk("rst_angle", {24'd0, angle}, 32'd90);
    chk("rst_lag", {27'd0, lag}, 32'd0);
    chk("rst_valid", {31'd0, angle_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;

    // aligned impulse
    push_exp(0);
    run_frame(100, 100, -1, 1'b1);
    wait_report(1'b1);
    chk("overrun_clean", {31'd0, overrun}, 32'd0);

    // channel 1 delayed by 3
    push_exp(3);
    run_frame(100, 103, -1, 1'b1);
    wait_report(1'b1);

    // unpaired: stored pair must be (B, ch1); A would give a negative peak
    push_exp(0);
    run_frame(-1, -1, 100, 1'b1);
    wait_report(1'b1);
    chk("overrun_set", {31'd0, overrun}, 32'd1);

    // channel 1 leading by 8
    push_exp(-8);
    run_frame(108, 100, -1, 1'b1);
    wait_report(1'b1);

    // lag +8: 178 with step 11, clamps to 180 with step 12
    push_exp(8);
    run_frame(100, 108, -1, 1'b1);
    wait_report(1'b1);

    // reset 1000 cycles into COMPUTE
    run_frame(100, 103, -1, 1'b1);
    seen = 1'b0;
    k = 0;
    while (k < 20 && !seen) begin
      @(negedge clock);
      seen = busy;
      k++;
    end
    chk("busy_started", {31'd0, seen}, 32'd1);
    repeat (1000) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_angle", {24'd0, angle}, 32'd90);
    chk("mid_rst_lag", {27'd0, lag}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (3500) begin
      @(negedge clock);
      if (angle_valid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", {31'd0, seen}, 32'd0);

    // all-zero frame
`ifdef TDOA_ENERGY_GATE_EN
    run_frame(-1, -1, -1, 1'b0);
    wait_report(1'b0);
    chk("gated_angle", {24'd0, angle}, 32'd90);
`else
    push_exp(0);
    run_frame(-1, -1, -1, 1'b0);
    wait_report(1'b1);
`endif

    // fresh frame after the aborted one
    push_exp(3);
    run_frame(100, 103, -1, 1'b1);
    wait_report(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
